interp_linear_mc: RTL and testbench

Parametrised successor to the DAC-side interpolation stage. Reads samples from the output FIFO and upsamples each channel by 2^RATE_LOG2 using run-time selectable zero-order-hold or linear interpolation. Output is one sample per clk, and feeds DAC_DRIVER. Adds multi-channel lanes, underrun detection and a source-empty-aware read handshake.

---
 rtl/interp_linear_mc.sv | 172 +++++++++++++++++
 tb/tb_interp_linear_mc.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/interp_linear_mc.sv
`default_nettype none
// ============================================================================
// Module   : interp_linear_mc
// Purpose  : Multi-lane 2^RATE_LOG2 upsampler with zero-order-hold or linear
//            interpolation, fed from a read-latency-1 FIFO, with underrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module interp_linear_mc #(
    parameter int DATA_WIDTH = 14,
    parameter int RATE_LOG2  = 3,
    parameter int CHANNELS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic                           src_empty,
    output logic                           rd_en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] dataIn,
    input  logic                           mode,
    output logic [CHANNELS*DATA_WIDTH-1:0] inter_data,
    output logic                           out_valid,
    output logic                           underrun
);

    localparam int                   c_prod_w     = DATA_WIDTH + RATE_LOG2 + 1;
    localparam logic [RATE_LOG2-1:0] c_phase_last = '1;
    localparam logic [RATE_LOG2-1:0] c_phase_one  = RATE_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_rd_en;
    logic [RATE_LOG2-1:0]           r_phase;
    logic [1:0]                     r_fill_cnt;
    logic                           r_rd_vld;
    logic                           r_skip;
    logic                           r_mode_q;
    logic                           r_out_valid;
    logic                           r_underrun;
    logic [CHANNELS*DATA_WIDTH-1:0] r_prev;
    logic [CHANNELS*DATA_WIDTH-1:0] r_cur;
    logic [CHANNELS*DATA_WIDTH-1:0] r_inter_data;
    logic [CHANNELS*DATA_WIDTH-1:0] w_y;
    logic                           w_phase0;
    logic                           w_phase_last;
    logic                           w_fill_done;

    assign w_phase0     = (r_phase == '0);
    assign w_phase_last = (r_phase == c_phase_last);
    // The first capture always happens while the issue count is still 1,
    // so a capture seen with the count at 2 is the second one.
    assign w_fill_done  = r_rd_vld && (r_fill_cnt == 2'd2);

    assign rd_en      = w_rd_en;
    assign inter_data = r_inter_data;
    assign out_valid  = r_out_valid;
    assign underrun   = r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ena) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                w_rd_en = !src_empty && (r_fill_cnt != 2'd2);
                if (w_fill_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_rd_en = w_phase_last && !src_empty;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase      <= '0;
            r_fill_cnt   <= '0;
            r_rd_vld     <= 1'b0;
            r_skip       <= 1'b0;
            r_mode_q     <= 1'b0;
            r_out_valid  <= 1'b0;
            r_underrun   <= 1'b0;
            r_prev       <= '0;
            r_cur        <= '0;
            r_inter_data <= '0;
        end else begin
            r_rd_vld <= w_rd_en;
            case (r_state)
                S_IDLE: begin
                    r_fill_cnt <= '0;
                    r_phase    <= '0;
                end
                S_FILL: begin
                    r_phase <= '0;
                    if (w_rd_en) begin
                        r_fill_cnt <= r_fill_cnt + 2'd1;
                    end
                    if (r_rd_vld) begin
                        r_prev <= r_cur;
                        r_cur  <= dataIn;
                    end
                end
                S_RUN: begin
                    r_phase <= r_phase + c_phase_one;
                    r_skip  <= w_phase_last && src_empty;
                    if (w_phase_last) begin
                        r_prev <= r_cur;
                    end
                    // A skipped read leaves cur untouched, giving a flat segment.
                    if (w_phase0) begin
                        r_mode_q <= mode;
                        if (r_rd_vld) begin
                            r_cur <= dataIn;
                        end
                        if (r_skip) begin
                            r_underrun <= 1'b1;
                        end
                    end
                    r_inter_data <= w_y;
                    r_out_valid  <= 1'b1;
                end
                default: begin
                    r_phase <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] w_prev_l;
        logic signed [DATA_WIDTH-1:0] w_cur_l;
        logic signed [DATA_WIDTH:0]   w_d;
        logic        [c_prod_w-1:0]   w_t;
        logic        [DATA_WIDTH:0]   w_sum;
        logic                         w_unused;

        assign w_prev_l = r_prev[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_cur_l  = r_cur[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_d      = {w_cur_l[DATA_WIDTH-1], w_cur_l} - {w_prev_l[DATA_WIDTH-1], w_prev_l};
        // Phase is non-negative, so a modular product of the sign-extended
        // delta yields the correct two's-complement result.
        assign w_t      = {{RATE_LOG2{w_d[DATA_WIDTH]}}, w_d} * {{(DATA_WIDTH+1){1'b0}}, r_phase};
        assign w_sum    = {w_prev_l[DATA_WIDTH-1], w_prev_l} + w_t[c_prod_w-1:RATE_LOG2];
        assign w_y[k*DATA_WIDTH +: DATA_WIDTH] = r_mode_q ? w_sum[DATA_WIDTH-1:0] : w_prev_l;
        // Result always lies between prev and cur, so the carry bit is redundant.
        assign w_unused = ^{w_sum[DATA_WIDTH], w_t[RATE_LOG2-1:0]};
    end

endmodule
`default_nettype wire

// File: tb/tb_interp_linear_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_interp_linear_mc
// Purpose  : Directed table-driven bench for interp_linear_mc (2 lanes, R=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_linear_mc;

    localparam int DW = 14;
    localparam int CH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ena;
    logic              src_empty;
    logic              rd_en;
    logic              mode;
    logic              out_valid;
    logic              underrun;
    logic [CH*DW-1:0]  dataIn = '0;
    logic [CH*DW-1:0]  inter_data;

    logic [CH*DW-1:0]  fifo_mem [0:63];
    int                wptr = 0;
    int                rptr = 0;
    int                n_tests = 0;
    int                n_fail = 0;

    typedef struct packed {
        logic               md;
        logic               md_late;
        logic               rd_ok;
        logic               und;
        logic               push;
        logic [DW-1:0]      push_val;
        logic [7:0][DW-1:0] e;
    } vec_t;

    vec_t tbl [12];

    interp_linear_mc #(
        .DATA_WIDTH (DW),
        .RATE_LOG2  (3),
        .CHANNELS   (CH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .src_empty  (src_empty),
        .rd_en      (rd_en),
        .dataIn     (dataIn),
        .mode       (mode),
        .inter_data (inter_data),
        .out_valid  (out_valid),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    // Source FIFO with one cycle of read latency.
    assign src_empty = (rptr == wptr);
    always @(posedge clk) begin
        if (rd_en && (rptr != wptr)) begin
            dataIn <= fifo_mem[rptr];
            rptr   <= rptr + 1;
        end
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int v0, input int v1);
        fifo_mem[wptr] = {DW'(v1), DW'(v0)};
        wptr = wptr + 1;
    endtask

    function automatic logic signed [31:0] lane(input int k);
        return 32'($signed(inter_data[k*DW +: DW]));
    endfunction

    task automatic row(input int k, input int md, input int ml, input int rdok, input int und,
                       input int pu, input int pv, input int e0, input int e1, input int e2,
                       input int e3, input int e4, input int e5, input int e6, input int e7);
        tbl[k].md       = (md != 0);
        tbl[k].md_late  = (ml != 0);
        tbl[k].rd_ok    = (rdok != 0);
        tbl[k].und      = (und != 0);
        tbl[k].push     = (pu != 0);
        tbl[k].push_val = DW'(pv);
        tbl[k].e[0] = DW'(e0); tbl[k].e[1] = DW'(e1);
        tbl[k].e[2] = DW'(e2); tbl[k].e[3] = DW'(e3);
        tbl[k].e[4] = DW'(e4); tbl[k].e[5] = DW'(e5);
        tbl[k].e[6] = DW'(e6); tbl[k].e[7] = DW'(e7);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // Segment table: md, md_late, rd_ok, underrun, push, push value, eight outputs.
        row(0,  1, 1, 1, 0, 0, 0,  0, 10, 20, 30, 40, 50, 60, 70);
        row(1,  1, 1, 1, 0, 0, 0,  80, 90, 100, 110, 120, 130, 140, 150);
        row(2,  1, 1, 1, 0, 0, 0,  160, 140, 120, 100, 80, 60, 40, 20);
        row(3,  1, 1, 1, 0, 0, 0,  0, -1, -1, -2, -2, -2, -3, -3);
        row(4,  1, 1, 1, 0, 0, 0,  -3, 1021, 2045, 3069, 4094, 5118, 6142, 7166);
        row(5,  1, 1, 1, 0, 0, 0,  8191, 6143, 4095, 2047, -1, -2049, -4097, -6145);
        row(6,  0, 0, 1, 0, 0, 0,  -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192);
        row(7,  0, 1, 1, 0, 0, 0,  5, 5, 5, 5, 5, 5, 5, 5);
        row(8,  1, 1, 1, 0, 0, 0,  9, 9, 10, 10, 11, 11, 12, 12);
        row(9,  1, 1, 0, 0, 0, 0,  13, 14, 15, 16, 17, 18, 19, 20);
        row(10, 1, 1, 1, 1, 1, 29, 21, 21, 21, 21, 21, 21, 21, 21);
        row(11, 1, 1, 0, 1, 0, 0,  21, 22, 23, 24, 25, 26, 27, 28);

        rst  = 1'b1;
        ena  = 1'b0;
        mode = 1'b1;
        push(0, 0);     push(80, 80);   push(160, 160); push(0, 0);
        push(-3, -3);   push(8191, 8191); push(-8192, -8192);
        push(5, 5);     push(9, 9);     push(13, 13);   push(21, 21);

        repeat (2) @(negedge clk);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_inter_data", 32'(inter_data), 0);
        chk("reset_underrun", underrun, 0);
        rst = 1'b0;

        @(negedge clk);
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("fill_out_valid", out_valid, 0);
        end

        for (int k = 0; k < 12; k++) begin
            for (int p = 0; p < 8; p++) begin
                @(negedge clk);
                chk($sformatf("seg%0d_p%0d_lane0", k, p), lane(0), 32'($signed(tbl[k].e[p])));
                chk($sformatf("seg%0d_p%0d_lane1", k, p), lane(1), 32'($signed(tbl[k].e[p])));
                chk($sformatf("seg%0d_p%0d_rd_en", k, p), rd_en, ((p == 6) && tbl[k].rd_ok) ? 1 : 0);
                chk($sformatf("seg%0d_p%0d_underrun", k, p), underrun, tbl[k].und);
                if (p == 0) begin
                    chk($sformatf("seg%0d_out_valid", k), out_valid, 1);
                end
                if (p == 2) begin
                    mode = tbl[k].md_late;
                    if (tbl[k].push) begin
                        push($signed(tbl[k].push_val), $signed(tbl[k].push_val));
                    end
                end
                if ((p == 6) && (k < 11)) begin
                    mode = tbl[k+1].md;
                end
            end
        end

        // Asynchronous reset mid-segment.
        repeat (4) @(posedge clk);
        #2;
        chk("underrun_before_rst", underrun, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_inter_data", 32'(inter_data), 0);
        chk("async_rst_underrun", underrun, 0);
        chk("async_rst_rd_en", rd_en, 0);
        @(negedge clk);
        rst = 1'b0;

        // Restart: data present but no read until ena, FILL stall is not an underrun.
        mode = 1'b1;
        push(0, 0);
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_rd_en", rd_en, 0);
        end
        ena = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        repeat (6) @(negedge clk);
        chk("fill_stall_underrun", underrun, 0);
        chk("fill_stall_out_valid", out_valid, 0);
        push(80, -80);
        push(160, -160);
        n = 0;
        while (!out_valid && (n < 20)) begin
            @(negedge clk);
            n++;
        end
        chk("restart_out_valid", out_valid, 1);
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("mc_p%0d_lane0", p), lane(0), 10 * p);
            chk($sformatf("mc_p%0d_lane1", p), lane(1), -10 * p);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
